// File: rtl/pipelined_wide_adder_pkg.sv
// Shared sizing helpers for the pipelined wide adder.
// Latency: none (compile-time constants and functions only).
// Backpressure: n/a.
package pipelined_wide_adder_pkg;

  // Integer ceiling division for elaboration-time sizing.
  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

  // Number of chunk stages needed to cover a w-bit add with c-bit chunks.
  function automatic int stages_of(input int w, input int c);
    return ceil_div(w, c);
  endfunction

  // Width of the top chunk, which absorbs the remainder when c does not divide w.
  function automatic int last_w_of(input int w, input int c);
    return w - (stages_of(w, c) - 1) * c;
  endfunction

endpackage

// File: rtl/adder_chunk_stage.sv
// One chunk of the carry-pipelined adder: registered CW-bit add with carry in/out.
// Latency: 1 cycle from operands to registered sum and carry.
// Backpressure: holds its registers whenever en_i is low.
module adder_chunk_stage #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic [CW-1:0] a_i,
  input  logic [CW-1:0] b_i,
  input  logic          c_i,
  output logic [CW-1:0] s_o,
  output logic          c_o
);

  logic [CW:0]   sum_d;
  logic [CW-1:0] s_q;
  logic          c_q;

  assign sum_d = {1'b0, a_i} + {1'b0, b_i} + {{CW{1'b0}}, c_i};
  assign s_o   = s_q;
  assign c_o   = c_q;

  // Capture chunk sum and carry-out when the pipeline advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q <= '0;
      c_q <= 1'b0;
    end else if (en_i) begin
      s_q <= sum_d[CW-1:0];
      c_q <= sum_d[CW];
    end
  end

endmodule

// File: rtl/pipelined_wide_adder.sv
// Pipelined WIDTH-bit add/subtract, one CHUNK-bit carry-registered slice per stage.
// Latency: STAGES cycles from acceptance to out_valid; one result per cycle unstalled.
// Backpressure: global advance; everything freezes and in_ready drops while out_valid && !out_ready.
module pipelined_wide_adder
  import pipelined_wide_adder_pkg::*;
#(
  parameter int WIDTH = 120,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int STAGES = stages_of(WIDTH, CHUNK);
  localparam int LAST_W = last_w_of(WIDTH, CHUNK);

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic             a_msb_q;
  logic             b_msb_q;

  // Subtraction is a + ~b + 1, so sub and carry_in are folded in before stage 0.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign b_eff    = sub ? ~b : b;
  assign c_eff    = sub | carry_in;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * CHUNK;
    localparam int IW = WIDTH - LO;
    localparam int CW = (k == STAGES - 1) ? LAST_W : CHUNK;

    // a_in/b_in hold only the operand bits not yet consumed by earlier stages.
    logic [IW-1:0] a_in;
    logic [IW-1:0] b_in;
    logic          c_in;
    logic          vld_in;
    logic          vld_q;
    logic [CW-1:0] s;
    logic          co;

    if (k == 0) begin : g_head
      assign a_in   = a;
      assign b_in   = b_eff;
      assign c_in   = c_eff;
      assign vld_in = in_valid;
    end else begin : g_body
      // Already-computed lower sum chunks, delayed to line up with this stage.
      logic [LO-1:0] lo_q;

      assign a_in   = g_stage[k-1].g_fwd.a_fwd_q;
      assign b_in   = g_stage[k-1].g_fwd.b_fwd_q;
      assign c_in   = g_stage[k-1].co;
      assign vld_in = g_stage[k-1].vld_q;

      if (k == 1) begin : g_first
        // Pick up chunk 0 of the sum as it leaves stage 0.
        always_ff @(posedge clk) begin
          if (rst)      lo_q <= '0;
          else if (adv) lo_q <= g_stage[0].s;
        end
      end else begin : g_rest
        // Append the previous stage's chunk above the chunks it carried.
        always_ff @(posedge clk) begin
          if (rst)      lo_q <= '0;
          else if (adv) lo_q <= {g_stage[k-1].s, g_stage[k-1].g_body.lo_q};
        end
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [IW-CW-1:0] a_fwd_q;
      logic [IW-CW-1:0] b_fwd_q;

      // Skew: pass the upper, still-unadded operand chunks to the next stage.
      always_ff @(posedge clk) begin
        if (adv) begin
          a_fwd_q <= a_in[IW-1:CW];
          b_fwd_q <= b_in[IW-1:CW];
        end
      end
    end

    // Per-stage valid bit; bubbles travel as zero.
    always_ff @(posedge clk) begin
      if (rst)      vld_q <= 1'b0;
      else if (adv) vld_q <= vld_in;
    end

    adder_chunk_stage #(
      .CW (CW)
    ) u_chunk (
      .clk  (clk),
      .rst  (rst),
      .en_i (adv),
      .a_i  (a_in[CW-1:0]),
      .b_i  (b_in[CW-1:0]),
      .c_i  (c_in),
      .s_o  (s),
      .c_o  (co)
    );
  end

  // Operand sign bits ride alongside the top chunk for the overflow decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
    end else if (adv) begin
      a_msb_q <= g_stage[STAGES-1].a_in[LAST_W-1];
      b_msb_q <= g_stage[STAGES-1].b_in[LAST_W-1];
    end
  end

  if (STAGES == 1) begin : g_sum_one
    assign sum = g_stage[0].s;
  end else begin : g_sum_many
    assign sum = {g_stage[STAGES-1].s, g_stage[STAGES-1].g_body.lo_q};
  end

  assign out_valid = g_stage[STAGES-1].vld_q;
  assign carry_out = g_stage[STAGES-1].co;
  assign overflow  = (a_msb_q == b_msb_q) && (sum[WIDTH-1] != a_msb_q);

endmodule

// File: tb/tb_pipelined_wide_adder.sv
// Bench for pipelined_wide_adder at WIDTH=120, CHUNK=16.
// Latency: checks results appear STAGES-1 edges after the accepting edge.
// Backpressure: exercises a mid-stream out_ready stall and a reset with work in flight.
module tb_pipelined_wide_adder;

  localparam int W   = 120;
  localparam int STG = 8;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  typedef struct {
    res_t r;
    int   acc;
    bit   chk_lat;
  } item_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carry_in;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         overflow;

  int    tests    = 0;
  int    fails    = 0;
  int    cyc      = 0;
  int    n_out    = 0;
  bit    lat_mode = 1'b1;
  item_t q[$];

  always #5 clk = ~clk;

  pipelined_wide_adder #(
    .WIDTH (W),
    .CHUNK (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: exact integer arithmetic, signed overflow as a range test.
  function automatic res_t model(input logic [W-1:0] va, input logic [W-1:0] vb,
                                 input logic vc, input logic vs);
    res_t r;
    logic [W:0] u;
    logic signed [W+1:0] sa, sb, sr, lim;
    sa  = $signed({{2{va[W-1]}}, va});
    sb  = $signed({{2{vb[W-1]}}, vb});
    lim = $signed({3'b001, {(W-1){1'b0}}});
    if (!vs) begin
      u      = {1'b0, va} + {1'b0, vb} + {{W{1'b0}}, vc};
      r.cout = u[W];
      sr     = sa + sb + $signed({{(W+1){1'b0}}, vc});
    end else begin
      u      = {1'b0, va} - {1'b0, vb};
      r.cout = (va >= vb);
      sr     = sa - sb;
    end
    r.sum = u[W-1:0];
    r.ovf = (sr >= lim) || (sr < -lim);
    return r;
  endfunction

  // Scoreboard: check outputs and handshake every cycle, track acceptances.
  always @(negedge clk) begin
    item_t it;
    item_t ni;
    if (rst) begin
      q.delete();
    end else begin
      chk("in_ready_rule", 128'(in_ready), 128'(!out_valid || out_ready));
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 128'(out_valid), 128'(0));
        end else begin
          it = q[0];
          chk("sum", 128'(sum), 128'(it.r.sum));
          chk("carry_out", 128'(carry_out), 128'(it.r.cout));
          chk("overflow", 128'(overflow), 128'(it.r.ovf));
          if (it.chk_lat) chk("latency", 128'(cyc - it.acc), 128'(STG - 1));
          if (out_ready) begin
            void'(q.pop_front());
            n_out++;
          end
        end
      end
      if (in_valid && in_ready) begin
        ni.r       = model(a, b, carry_in, sub);
        ni.acc     = cyc + 1;
        ni.chk_lat = lat_mode;
        q.push_back(ni);
      end
    end
  end

  task automatic push(input logic [W-1:0] va, input logic [W-1:0] vb,
                      input logic vc, input logic vs);
    int k;
    a = va; b = vb; carry_in = vc; sub = vs; in_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) chk("accept_timeout", 128'(in_ready), 128'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    chk("drain_timeout", 128'(q.size()), 128'(0));
    #1;
  endtask

  task automatic directed(input string nm, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic vc, input logic vs,
                          input logic [W-1:0] es, input logic ec, input logic eo);
    res_t m;
    int k;
    m = model(va, vb, vc, vs);
    chk({nm, "_model_sum"}, 128'(m.sum), 128'(es));
    chk({nm, "_model_cout"}, 128'(m.cout), 128'(ec));
    chk({nm, "_model_ovf"}, 128'(m.ovf), 128'(eo));
    push(va, vb, vc, vs);
    in_valid = 1'b0;
    k = 0;
    @(negedge clk);
    while (!out_valid && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_edges"}, 128'(k), 128'(STG - 1));
    chk({nm, "_sum"}, 128'(sum), 128'(es));
    chk({nm, "_cout"}, 128'(carry_out), 128'(ec));
    chk({nm, "_ovf"}, 128'(overflow), 128'(eo));
    @(posedge clk);
    #1;
  endtask

  task automatic push_random();
    logic [127:0] r1;
    logic [127:0] r2;
    r1 = {$urandom(), $urandom(), $urandom(), $urandom()};
    r2 = {$urandom(), $urandom(), $urandom(), $urandom()};
    push(r1[W-1:0], r2[W-1:0], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    int n0;
    logic [W-1:0] ones;
    logic [W-1:0] half;
    ones = {W{1'b1}};
    half = {1'b1, {(W-1){1'b0}}};
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; carry_in = 1'b0; sub = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_sum", 128'(sum), 128'(0));
    chk("rst_cout", 128'(carry_out), 128'(0));
    chk("rst_ovf", 128'(overflow), 128'(0));
    @(posedge clk);
    #1;

    directed("allones_plus_cin", ones, '0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    directed("five_minus_seven", W'(5), W'(7), 1'b1, 1'b1, ones - W'(1), 1'b0, 1'b0);
    directed("max_plus_one", half - W'(1), W'(1), 1'b0, 1'b0, half, 1'b0, 1'b1);
    directed("min_minus_one", half, W'(1), 1'b0, 1'b1, half - W'(1), 1'b1, 1'b1);
    directed("equal_sub", W'(32'h1234), W'(32'h1234), 1'b0, 1'b1, '0, 1'b1, 1'b0);

    // 100 back-to-back random sets with the sink always ready.
    n0 = n_out;
    for (int i = 0; i < 100; i++) push_random();
    in_valid = 1'b0;
    wait_drain();
    chk("burst_count", 128'(n_out - n0), 128'(100));

    // Stream with a 5-cycle sink stall in the middle.
    lat_mode = 1'b0;
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 20; i++) push_random();
        in_valid = 1'b0;
      end
      begin
        repeat (12) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          chk("stall_in_ready", 128'(in_ready), 128'(0));
          chk("stall_out_valid", 128'(out_valid), 128'(1));
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();
    chk("stall_count", 128'(n_out - n0), 128'(20));
    lat_mode = 1'b1;

    // Reset with four sets in flight.
    for (int i = 0; i < 4; i++) push_random();
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_out_valid", 128'(out_valid), 128'(0));
    chk("post_rst_in_ready", 128'(in_ready), 128'(1));
    chk("post_rst_sum", 128'(sum), 128'(0));
    repeat (12) @(posedge clk);
    #1;
    directed("after_reset", W'(123), W'(456), 1'b1, 1'b0, W'(580), 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

endmodule
